// File: rtl/op_downscale_pkg.sv
// Shared constants and helpers for the CORDIC output downscaler: guard-bit count and
// two's-complement saturation limits.
package op_downscale_pkg;

    localparam int DATA_WIDTH_DEF   = 32;
    localparam int CORDIC_WIDTH_DEF = 40;

    // Number of guard fraction bits dropped on the way out of the CORDIC core.
    function automatic int frac_bits(input int cordic_width, input int data_width);
        return cordic_width - data_width;
    endfunction

    function automatic logic [63:0] sat_max(input int width);
        return (64'd1 << (width - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_min(input int width);
        return 64'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/op_downscale_if.sv
// Valid/ready bus between the CORDIC core, the downscaler and the consumer.
interface op_downscale_if
    import op_downscale_pkg::*;
#(
    parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int CORDIC_WIDTH = CORDIC_WIDTH_DEF
);
    logic [CORDIC_WIDTH-1:0] x_in;
    logic [CORDIC_WIDTH-1:0] y_in;
    logic                    in_vld;
    logic                    in_rdy;
    logic [DATA_WIDTH-1:0]   x_out;
    logic [DATA_WIDTH-1:0]   y_out;
    logic                    op_vld;
    logic                    out_rdy;
    logic                    sat;

    modport slave (
        input  x_in, y_in, in_vld, out_rdy,
        output in_rdy, x_out, y_out, op_vld, sat
    );

    modport master (
        output x_in, y_in, in_vld, out_rdy,
        input  in_rdy, x_out, y_out, op_vld, sat
    );
endinterface

// File: rtl/op_downscale_lane.sv
// One coordinate of the downscaler: round into S1, reduce and saturate into S2.
// Rounding and saturation exist only when OP_DOWNSCALE_ROUND_EN is defined.
module op_downscale_lane
    import op_downscale_pkg::*;
#(
    parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int CORDIC_WIDTH = CORDIC_WIDTH_DEF
) (
    input  logic                    clk,
    input  logic                    nreset,
    input  logic                    s1_take,
    input  logic                    s2_take,
    input  logic [CORDIC_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0]   dout,
    output logic                    ovf
);
    localparam int F = frac_bits(CORDIC_WIDTH, DATA_WIDTH);
    localparam logic [63:0]         MAX64     = sat_max(DATA_WIDTH);
    localparam logic [63:0]         MIN64     = sat_min(DATA_WIDTH);
    localparam logic [DATA_WIDTH-1:0] SAT_POS = MAX64[DATA_WIDTH-1:0];
    localparam logic [DATA_WIDTH-1:0] SAT_NEG = MIN64[DATA_WIDTH-1:0];
    localparam logic [CORDIC_WIDTH:0] HALF_LSB = {{CORDIC_WIDTH{1'b0}}, 1'b1} << (F - 1);

    logic [CORDIC_WIDTH:0]   v_s;
    logic [CORDIC_WIDTH:0]   s1_d;
    logic [CORDIC_WIDTH:0]   s1_q;
    logic [DATA_WIDTH:0]     r_s;
    logic [DATA_WIDTH-1:0]   res_s;
    logic [DATA_WIDTH-1:0]   s2_d;
    logic [DATA_WIDTH-1:0]   s2_q;
    logic                    ovf_s;
    logic                    frac_unused_s;

    // Sign-extend by one bit so the half-LSB add cannot wrap.
    always_comb begin
`ifdef OP_DOWNSCALE_ROUND_EN
        v_s = {din[CORDIC_WIDTH-1], din} + HALF_LSB;
`else
        v_s = {din[CORDIC_WIDTH-1], din};
`endif
    end

    // Drop the guard bits; clamp when the kept sign bit and the next bit disagree.
    always_comb begin
        r_s   = s1_q[CORDIC_WIDTH:F];
        ovf_s = 1'b0;
        res_s = r_s[DATA_WIDTH-1:0];
`ifdef OP_DOWNSCALE_ROUND_EN
        if (r_s[DATA_WIDTH] != r_s[DATA_WIDTH-1]) begin
            ovf_s = 1'b1;
            res_s = r_s[DATA_WIDTH] ? SAT_NEG : SAT_POS;
        end else begin
            ovf_s = 1'b0;
            res_s = r_s[DATA_WIDTH-1:0];
        end
`endif
    end

    assign frac_unused_s = ^{s1_q[F-1:0], r_s[DATA_WIDTH]};

    // Payload next-state: a stage only captures when a valid word moves into it.
    always_comb begin
        if (s1_take) begin
            s1_d = v_s;
        end else begin
            s1_d = s1_q;
        end
        if (s2_take) begin
            s2_d = res_s;
        end else begin
            s2_d = s2_q;
        end
    end

    // Payload registers.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            s1_q <= {(CORDIC_WIDTH+1){1'b0}};
            s2_q <= {DATA_WIDTH{1'b0}};
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign dout = s2_q;
    assign ovf  = ovf_s;
endmodule

// File: rtl/op_downscale.sv
// CORDIC_WIDTH -> DATA_WIDTH output downscaler, two registered stages with valid/ready.
// Define OP_DOWNSCALE_ROUND_EN for round-half-up with saturation; otherwise floor truncation.
module op_downscale
    import op_downscale_pkg::*;
#(
    parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int CORDIC_WIDTH = CORDIC_WIDTH_DEF
) (
    input  logic            clk,
    input  logic            nreset,
    op_downscale_if.slave   bus
);
    logic s1_vld_d;
    logic s1_vld_q;
    logic s2_vld_d;
    logic s2_vld_q;
    logic s1_load_s;
    logic s2_load_s;
    logic s1_take_s;
    logic s2_take_s;
    logic sat_d;
    logic sat_q;
    logic x_ovf_s;
    logic y_ovf_s;

    // A stage may load when it is empty or its contents move on this cycle;
    // in_rdy therefore never depends on in_vld.
    always_comb begin
        s2_load_s = !s2_vld_q || bus.out_rdy;
        s1_load_s = !s1_vld_q || s2_load_s;
        s1_take_s = s1_load_s && bus.in_vld;
        s2_take_s = s2_load_s && s1_vld_q;
    end

    // Valid bits and the combined saturation flag follow the payload into S2.
    always_comb begin
        if (s1_load_s) begin
            s1_vld_d = bus.in_vld;
        end else begin
            s1_vld_d = s1_vld_q;
        end
        if (s2_load_s) begin
            s2_vld_d = s1_vld_q;
        end else begin
            s2_vld_d = s2_vld_q;
        end
        if (s2_take_s) begin
            sat_d = x_ovf_s | y_ovf_s;
        end else begin
            sat_d = sat_q;
        end
    end

    // Control registers.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            s1_vld_q <= 1'b0;
            s2_vld_q <= 1'b0;
            sat_q    <= 1'b0;
        end else begin
            s1_vld_q <= s1_vld_d;
            s2_vld_q <= s2_vld_d;
            sat_q    <= sat_d;
        end
    end

    op_downscale_lane #(
        .DATA_WIDTH   (DATA_WIDTH),
        .CORDIC_WIDTH (CORDIC_WIDTH)
    ) u_lane_x (
        .clk     (clk),
        .nreset  (nreset),
        .s1_take (s1_take_s),
        .s2_take (s2_take_s),
        .din     (bus.x_in),
        .dout    (bus.x_out),
        .ovf     (x_ovf_s)
    );

    op_downscale_lane #(
        .DATA_WIDTH   (DATA_WIDTH),
        .CORDIC_WIDTH (CORDIC_WIDTH)
    ) u_lane_y (
        .clk     (clk),
        .nreset  (nreset),
        .s1_take (s1_take_s),
        .s2_take (s2_take_s),
        .din     (bus.y_in),
        .dout    (bus.y_out),
        .ovf     (y_ovf_s)
    );

    assign bus.in_rdy = s1_load_s;
    assign bus.op_vld = s2_vld_q;
    assign bus.sat    = sat_q;
endmodule

// File: tb/tb_op_downscale.sv
// Self-checking bench for op_downscale at DATA_WIDTH=16, CORDIC_WIDTH=22, against an
// arithmetic reference model and a queue of in-flight words.
module tb_op_downscale;
    localparam int DW = 16;
    localparam int CW = 22;
    localparam int F  = CW - DW;
    localparam longint MAXV = (longint'(1) <<< (DW - 1)) - 1;
    localparam longint MINV = -(longint'(1) <<< (DW - 1));

    logic clk = 1'b0;
    logic nreset;
    always #5 clk = ~clk;

    op_downscale_if #(.DATA_WIDTH(DW), .CORDIC_WIDTH(CW)) bus ();

    op_downscale #(.DATA_WIDTH(DW), .CORDIC_WIDTH(CW)) dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus.slave)
    );

    typedef struct {
        logic [DW-1:0] x;
        logic [DW-1:0] y;
        logic          sat;
        int            edge_n;
    } exp_t;

    int            total = 0;
    int            bad   = 0;
    int            k     = 0;
    exp_t          q[$];
    logic [DW-1:0] seen_x[$];
    bit            saw_block;

    // Value / 2^F, rounded half up or floored, clamped to the DATA_WIDTH range.
    function automatic logic [DW:0] ref_down(input logic [CW-1:0] v);
        longint      s;
        logic [63:0] t;
        logic        flag;
        s = longint'($signed(v));
`ifdef OP_DOWNSCALE_ROUND_EN
        s = s + (longint'(1) <<< (F - 1));
`endif
        s    = s >>> F;
        flag = 1'b0;
        if (s > MAXV) begin
            s = MAXV; flag = 1'b1;
        end else if (s < MINV) begin
            s = MINV; flag = 1'b1;
        end
        t = s;
        return {flag, t[DW-1:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, compare against the model, then advance the model
    // past the posedge. The buffer holds two words; a word captured at edge a is
    // visible from edge a+1 once it reaches the head of the queue.
    task automatic cycle(input logic v, input logic [CW-1:0] x, input logic [CW-1:0] y,
                         input logic ordy);
        logic          exp_vld;
        logic          exp_rdy;
        logic          acc_in;
        logic          acc_out;
        logic [DW-1:0] obs_x;
        logic [DW:0]   rx;
        logic [DW:0]   ry;
        exp_t          e;
        @(negedge clk);
        bus.in_vld  = v;
        bus.x_in    = x;
        bus.y_in    = y;
        bus.out_rdy = ordy;
        #1;
        exp_vld = 1'b0;
        if (q.size() > 0) exp_vld = (k > q[0].edge_n);
        exp_rdy = (q.size() < 2) || ordy;
        check("op_vld", 32'(bus.op_vld), 32'(exp_vld));
        check("in_rdy", 32'(bus.in_rdy), 32'(exp_rdy));
        if (exp_vld) begin
            check("x_out", 32'(bus.x_out), 32'(q[0].x));
            check("y_out", 32'(bus.y_out), 32'(q[0].y));
            check("sat",   32'(bus.sat),   32'(q[0].sat));
        end
        if (v && !bus.in_rdy) saw_block = 1'b1;
        obs_x   = bus.x_out;
        acc_out = exp_vld && ordy;
        acc_in  = v && exp_rdy && nreset;
        @(posedge clk);
        k++;
        if (acc_out) begin
            seen_x.push_back(obs_x);
            void'(q.pop_front());
        end
        if (acc_in) begin
            rx       = ref_down(x);
            ry       = ref_down(y);
            e.x      = rx[DW-1:0];
            e.y      = ry[DW-1:0];
            e.sat    = rx[DW] | ry[DW];
            e.edge_n = k;
            q.push_back(e);
        end
    endtask

    task automatic directed(input string tag, input logic [CW-1:0] x, input logic [CW-1:0] y,
                            input logic [DW-1:0] ex, input logic [DW-1:0] ey, input logic es);
        cycle(1'b1, x, y, 1'b1);
        cycle(1'b0, '0, '0, 1'b1);
        #2;
        check({tag, "_vld"}, 32'(bus.op_vld), 32'd1);
        check({tag, "_x"},   32'(bus.x_out),  32'(ex));
        check({tag, "_y"},   32'(bus.y_out),  32'(ey));
        check({tag, "_sat"}, 32'(bus.sat),    32'(es));
    endtask

    function automatic logic [CW-1:0] pick_val();
        logic [CW-1:0] r;
        r = CW'($urandom);
        case ($urandom_range(0, 3))
            0: pick_val = r;
            1: pick_val = 22'h1FFFFF - CW'($urandom_range(0, 100));
            2: pick_val = 22'h200000 + CW'($urandom_range(0, 100));
            default: pick_val = (r & 22'h3FFFC0) | 22'h000020;
        endcase
    endfunction

    initial begin
        int sent;
        nreset      = 1'b0;
        bus.in_vld  = 1'b0;
        bus.x_in    = '0;
        bus.y_in    = '0;
        bus.out_rdy = 1'b0;
        saw_block   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_x_out",  32'(bus.x_out),  32'd0);
        check("rst_y_out",  32'(bus.y_out),  32'd0);
        check("rst_op_vld", 32'(bus.op_vld), 32'd0);
        check("rst_sat",    32'(bus.sat),    32'd0);
        @(negedge clk);
        nreset = 1'b1;
        #1;
        check("rst_in_rdy", 32'(bus.in_rdy), 32'd1);

`ifdef OP_DOWNSCALE_ROUND_EN
        directed("half_lsb", 22'h000020, 22'h000000, 16'h0001, 16'h0000, 1'b0);
        directed("neg_half", 22'h3FFFE0, 22'h000020, 16'h0000, 16'h0001, 1'b0);
        directed("overflow", 22'h1FFFE0, 22'h000000, 16'h7FFF, 16'h0000, 1'b1);
        directed("most_neg", 22'h200000, 22'h200000, 16'h8000, 16'h8000, 1'b0);
`else
        directed("half_lsb", 22'h000020, 22'h000000, 16'h0000, 16'h0000, 1'b0);
        directed("neg_half", 22'h3FFFE0, 22'h000020, 16'hFFFF, 16'h0000, 1'b0);
        directed("overflow", 22'h1FFFE0, 22'h000000, 16'h7FFF, 16'h0000, 1'b0);
        directed("most_neg", 22'h200000, 22'h200000, 16'h8000, 16'h8000, 1'b0);
`endif
        repeat (2) cycle(1'b0, '0, '0, 1'b1);

        // Back-pressure: stream 1..5 with the consumer stalled for cycles 3..6.
        seen_x.delete();
        saw_block = 1'b0;
        sent      = 0;
        for (int c = 0; c < 30 && (sent < 5 || q.size() > 0); c++) begin
            logic ordy;
            logic will_take;
            ordy      = !(c >= 3 && c <= 6);
            will_take = (sent < 5) && ((q.size() < 2) || ordy);
            cycle(sent < 5, CW'(sent + 1) << F, CW'(sent + 1), ordy);
            if (will_take) sent++;
        end
        check("bp_in_rdy_fell", 32'(saw_block), 32'd1);
        check("bp_count", 32'(seen_x.size()), 32'd5);
        for (int i = 0; i < seen_x.size(); i++) begin
            check("bp_order", 32'(seen_x[i]), 32'(i + 1));
        end

        // Random traffic with random back-pressure.
        for (int c = 0; c < 400; c++) begin
            cycle($urandom_range(0, 3) != 0, pick_val(), pick_val(), $urandom_range(0, 2) != 0);
        end
        repeat (4) cycle(1'b0, '0, '0, 1'b1);
        check("drained", 32'(q.size()), 32'd0);

        // Reset with both stages full.
        cycle(1'b1, 22'h000440, 22'h000080, 1'b0);
        cycle(1'b1, 22'h000880, 22'h0000C0, 1'b0);
        cycle(1'b0, '0, '0, 1'b0);
        #2;
        check("full_before_rst", 32'(q.size()), 32'd2);
        nreset = 1'b0;
        #1;
        check("mid_rst_op_vld", 32'(bus.op_vld), 32'd0);
        check("mid_rst_x_out",  32'(bus.x_out),  32'd0);
        check("mid_rst_y_out",  32'(bus.y_out),  32'd0);
        check("mid_rst_sat",    32'(bus.sat),    32'd0);
        check("mid_rst_in_rdy", 32'(bus.in_rdy), 32'd1);
        q.delete();
        repeat (2) cycle(1'b0, '0, '0, 1'b1);
        #2;
        nreset = 1'b1;
        repeat (4) cycle(1'b0, '0, '0, 1'b1);
        cycle(1'b1, 22'h001000, 22'h3FF000, 1'b1);
        repeat (3) cycle(1'b0, '0, '0, 1'b1);
        check("post_rst_drained", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
